// File: rtl/relu_node_queue_pkg.sv
// Default ReLU queue geometry, shared with the rest of the network.
package relu_pkg;

  localparam int RELU_NODES   = 3;
  localparam int IN_BIT_WIDTH = 4;
  localparam int INDEX_WIDTH  = (RELU_NODES > 1) ? $clog2(RELU_NODES) : 1;

  // MSB position of node `node` in the packed value bus (node 0 occupies the top slice).
  function automatic int unsigned sliceMsb(input int unsigned node,
                                           input int unsigned nodes,
                                           input int unsigned width);
    return (nodes - node) * width - 1;
  endfunction

endpackage

// File: rtl/relu_node_queue_if.sv
// Load/pop/head bus of the ReLU node queue.
interface relu_node_queue_if #(
  parameter int RELU_NODES   = relu_pkg::RELU_NODES,
  parameter int IN_BIT_WIDTH = relu_pkg::IN_BIT_WIDTH,
  parameter int INDEX_WIDTH  = relu_pkg::INDEX_WIDTH
) ();

  logic [RELU_NODES*IN_BIT_WIDTH-1:0] ReluNodeValues;
  logic                               writeEnable;
  logic                               dequeue;
  logic [INDEX_WIDTH-1:0]             indexOut;
  logic [IN_BIT_WIDTH-1:0]            NodeValueOut;
  logic                               queueEmpty;

  modport master (
    output ReluNodeValues, writeEnable, dequeue,
    input  indexOut, NodeValueOut, queueEmpty
  );

  modport slave (
    input  ReluNodeValues, writeEnable, dequeue,
    output indexOut, NodeValueOut, queueEmpty
  );

endinterface

// File: rtl/relu_node_queue_first_set.sv
// Lowest-set-bit priority encoder: index of the lowest set bit plus an any-set flag.
module relu_first_set #(
  parameter int WIDTH       = relu_pkg::RELU_NODES,
  parameter int INDEX_WIDTH = relu_pkg::INDEX_WIDTH
) (
  input  logic [WIDTH-1:0]       pending,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   anySet
);

  always_comb begin
    index  = '0;
    anySet = |pending;
    // Scan from the top down so the lowest set bit is the last to overwrite.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (pending[WIDTH-1-i]) index = INDEX_WIDTH'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/relu_node_queue.sv
// ReLU node queue: loads all node values at once and drains them in ascending index order.
// Build option: RELU_NODE_QUEUE_ZERO_SKIP_EN makes zero-valued slots skip the queue.
module relu_node_queue
  import relu_pkg::*;
#(
  parameter int RELU_NODES   = relu_pkg::RELU_NODES,
  parameter int IN_BIT_WIDTH = relu_pkg::IN_BIT_WIDTH,
  parameter int INDEX_WIDTH  = relu_pkg::INDEX_WIDTH
) (
  input logic               clk,
  input logic               reset,
  relu_node_queue_if.slave  bus
);

  logic [IN_BIT_WIDTH-1:0] slotValue [RELU_NODES];
  logic [RELU_NODES-1:0]   pending;
  logic [RELU_NODES-1:0]   eligible;
  logic [RELU_NODES-1:0]   headOneHot;
  logic [INDEX_WIDTH-1:0]  headIdx;
  logic                    anySet;

  relu_first_set #(
    .WIDTH       (RELU_NODES),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) uFirstSet (
    .pending (pending),
    .index   (headIdx),
    .anySet  (anySet)
  );

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < RELU_NODES; i++) begin
`ifdef RELU_NODE_QUEUE_ZERO_SKIP_EN
      eligible[i] = |bus.ReluNodeValues[sliceMsb(i, RELU_NODES, IN_BIT_WIDTH) -: IN_BIT_WIDTH];
`else
      eligible[i] = 1'b1;
`endif
    end
  end

  always_comb begin
    headOneHot = '0;
    for (int unsigned i = 0; i < RELU_NODES; i++) begin
      headOneHot[i] = anySet && (headIdx == INDEX_WIDTH'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      for (int unsigned i = 0; i < RELU_NODES; i++) slotValue[i] <= '0;
    end else if (bus.writeEnable) begin
      pending <= eligible;
      for (int unsigned i = 0; i < RELU_NODES; i++) begin
        slotValue[i] <= bus.ReluNodeValues[sliceMsb(i, RELU_NODES, IN_BIT_WIDTH) -: IN_BIT_WIDTH];
      end
    end else if (bus.dequeue && anySet) begin
      pending <= pending & ~headOneHot;
    end
  end

  // One-hot select avoids indexing the slot array with an out-of-range encoder value.
  always_comb begin
    bus.NodeValueOut = '0;
    for (int unsigned i = 0; i < RELU_NODES; i++) begin
      if (headOneHot[i]) bus.NodeValueOut = slotValue[i];
    end
    bus.indexOut   = headIdx;
    bus.queueEmpty = ~anySet;
  end

endmodule

// File: tb/tb_relu_node_queue.sv
// Directed self-checking bench for relu_node_queue (default and zero-skip builds).
module tb_relu_node_queue;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  relu_node_queue_if bus ();

  relu_node_queue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkHead(input string tag, input int expIdx, input int expVal, input bit expEmpty);
    checkOne({tag, ".index"}, 32'(bus.indexOut), 32'(expIdx));
    checkOne({tag, ".value"}, 32'(bus.NodeValueOut), 32'(expVal));
    checkOne({tag, ".empty"}, 32'(bus.queueEmpty), 32'(expEmpty));
  endtask

  task automatic load(input logic [11:0] values);
    bus.ReluNodeValues = values;
    bus.writeEnable    = 1'b1;
    step();
    bus.writeEnable    = 1'b0;
  endtask

  task automatic pop();
    bus.dequeue = 1'b1;
    step();
    bus.dequeue = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.ReluNodeValues = '0;
    bus.writeEnable    = 1'b0;
    bus.dequeue        = 1'b0;
    step();
    step();
    reset = 1'b0;
    checkHead("reset", 0, 0, 1'b1);

    // Dequeue while empty is ignored
    pop();
    checkHead("emptyPop", 0, 0, 1'b1);
    step();
    checkHead("emptyPopHold", 0, 0, 1'b1);

    // Basic load and single-cycle drain
    load(12'b0110_0111_0011);
    checkHead("drain0", 0, 6, 1'b0);
    pop();
    checkHead("drain1", 1, 7, 1'b0);
    pop();
    checkHead("drain2", 2, 3, 1'b0);
    pop();
    checkHead("drainEnd", 0, 0, 1'b1);

    // Zero-valued slots
    load(12'b0000_0101_0000);
`ifdef RELU_NODE_QUEUE_ZERO_SKIP_EN
    checkHead("zero0", 1, 5, 1'b0);
    pop();
    checkHead("zeroEnd", 0, 0, 1'b1);
    load(12'b0000_0000_0000);
    checkHead("allZero", 0, 0, 1'b1);
`else
    checkHead("zero0", 0, 0, 1'b0);
    pop();
    checkHead("zero1", 1, 5, 1'b0);
    pop();
    checkHead("zero2", 2, 0, 1'b0);
    pop();
    checkHead("zeroEnd", 0, 0, 1'b1);
`endif

    // Write wins over a simultaneous dequeue
    load(12'b0110_0111_0011);
    pop();
    checkHead("preOverwrite", 1, 7, 1'b0);
    bus.ReluNodeValues = 12'b0001_0010_0100;
    bus.writeEnable    = 1'b1;
    bus.dequeue        = 1'b1;
    step();
    bus.writeEnable    = 1'b0;
    bus.dequeue        = 1'b0;
    checkHead("overwrite0", 0, 1, 1'b0);
    pop();
    checkHead("overwrite1", 1, 2, 1'b0);
    pop();
    checkHead("overwrite2", 2, 4, 1'b0);
    pop();
    checkHead("overwriteEnd", 0, 0, 1'b1);

    // Reset mid-drain beats a concurrent write and dequeue
    load(12'b0110_0111_0011);
    pop();
    checkHead("preReset", 1, 7, 1'b0);
    reset              = 1'b1;
    bus.ReluNodeValues = 12'b0001_0010_0100;
    bus.writeEnable    = 1'b1;
    bus.dequeue        = 1'b1;
    step();
    reset           = 1'b0;
    bus.writeEnable = 1'b0;
    bus.dequeue     = 1'b0;
    checkHead("midReset", 0, 0, 1'b1);

    // Held dequeue pops one entry per cycle
    load(12'b0110_0111_0011);
    checkHead("hold0", 0, 6, 1'b0);
    bus.dequeue = 1'b1;
    step();
    checkHead("hold1", 1, 7, 1'b0);
    step();
    checkHead("hold2", 2, 3, 1'b0);
    step();
    checkHead("holdEnd", 0, 0, 1'b1);
    step();
    checkHead("holdPastEmpty", 0, 0, 1'b1);
    bus.dequeue = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
